// File: rtl/wb_merge_pkg.sv
// Shared types for the write-back merge block: channel program-order slots,
// the buffered write entry and the merge mode.
package wb_merge_pkg;

  localparam int unsigned WB_CH_LOAD = 0;
  localparam int unsigned WB_CH_P0   = 1;
  localparam int unsigned WB_CH_P1   = 2;
  localparam int unsigned WB_NCH     = 3;
  localparam int unsigned WB_ENT_W   = 37;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  typedef enum logic {
    MODE_EMPTY,
    MODE_DRAIN
  } wb_mode_e;

endpackage

// File: rtl/wb_merge_fifo.sv
// Circular buffer of pending register writes: 0..3 pushes and 0..2 pops per cycle.
// Head view and entry array are exported for forwarding when WB_MERGE_FWD_EN is defined.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    i_push_cnt,
  input  wb_ent_t       i_push_ent [WB_NCH],
  input  logic [1:0]    i_pop_cnt,
  output wb_ent_t       o_head0,
  output wb_ent_t       o_head1,
  output logic [AW:0]   o_cnt
`ifdef WB_MERGE_FWD_EN
  , output logic [AW-1:0] o_head_ptr
  , output wb_ent_t       o_mem [DEPTH]
`endif
);

  wb_ent_t       r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_cnt;

  logic [AW:0]   w_free;
  logic [AW:0]   w_push_n;
  logic [AW:0]   w_pop_n;

  assign w_free   = (AW+1)'(DEPTH) - r_cnt;
  // Pushes beyond the free space are dropped so the count saturates at DEPTH.
  assign w_push_n = ((AW+1)'(i_push_cnt) > w_free) ? w_free : (AW+1)'(i_push_cnt);
  assign w_pop_n  = ((AW+1)'(i_pop_cnt) > r_cnt) ? r_cnt : (AW+1)'(i_pop_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      assert ((AW+1)'(i_push_cnt) <= w_free)
        else $error("wb_fifo: enqueue while full, write dropped");
      r_tail <= r_tail + w_push_n[AW-1:0];
      r_head <= r_head + w_pop_n[AW-1:0];
      r_cnt  <= r_cnt + w_push_n - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < WB_NCH; k++) begin
        if ((AW+1)'(k) < w_push_n) r_mem[r_tail + AW'(k)] <= i_push_ent[k];
      end
    end
  end

  assign o_head0 = r_mem[r_head];
  assign o_head1 = r_mem[r_head + AW'(1)];
  assign o_cnt   = r_cnt;
`ifdef WB_MERGE_FWD_EN
  assign o_head_ptr = r_head;
  assign o_mem      = r_mem;
`endif

endmodule

// File: rtl/wb_merge.sv
// Merges three write-back channels onto two register-file write ports, in program order,
// buffering overflow. Optional forwarding of buffered writes: macro WB_MERGE_FWD_EN.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0,
  input  logic [4:0]    rd0,
  input  logic [31:0]   wdata0,
  input  logic          we1,
  input  logic [4:0]    rd1,
  input  logic [31:0]   wdata1,
  input  logic          we2,
  input  logic [4:0]    rd2,
  input  logic [31:0]   wdata2,
  output logic          rf_we_a,
  output logic [4:0]    rf_waddr_a,
  output logic [31:0]   rf_wdata_a,
  output logic          rf_we_b,
  output logic [4:0]    rf_waddr_b,
  output logic [31:0]   rf_wdata_b,
  output logic          wb_stall,
  output logic [AW:0]   fifo_cnt,
  input  logic [4:0]    rs_q0,
  input  logic [4:0]    rs_q1,
  output logic          fwd_hit0,
  output logic          fwd_hit1,
  output logic [31:0]   fwd_data0,
  output logic [31:0]   fwd_data1
);

  wb_ent_t           w_in   [WB_NCH];
  logic [WB_NCH-1:0] w_vld;
  wb_ent_t           w_cmp  [WB_NCH];
  logic [1:0]        w_ncmp;
  wb_ent_t           w_push_ent [WB_NCH];
  logic [1:0]        w_push_cnt;
  logic [1:0]        w_pop_cnt;
  wb_ent_t           w_head0;
  wb_ent_t           w_head1;
  logic [AW:0]       w_fcnt;
  wb_mode_e          w_mode;
  wb_ent_t           w_iss_a;
  wb_ent_t           w_iss_b;
  logic              w_iss_a_v;
  logic              w_iss_b_v;
  logic              w_kill_a;

  assign w_in[WB_CH_LOAD] = '{rd: rd2, data: wdata2};
  assign w_in[WB_CH_P0]   = '{rd: rd0, data: wdata0};
  assign w_in[WB_CH_P1]   = '{rd: rd1, data: wdata1};
  assign w_vld[WB_CH_LOAD] = we2 && (rd2 != '0);
  assign w_vld[WB_CH_P0]   = we0 && (rd0 != '0);
  assign w_vld[WB_CH_P1]   = we1 && (rd1 != '0);

  // Pack valid requests oldest-first so slot k is the k-th write in program order.
  always_comb begin
    w_cmp  = '{default: '0};
    w_ncmp = '0;
    for (int unsigned c = 0; c < WB_NCH; c++) begin
      if (w_vld[c]) begin
        w_cmp[w_ncmp] = w_in[c];
        w_ncmp        = w_ncmp + 2'd1;
      end
    end
  end

  assign w_mode = (w_fcnt == '0) ? MODE_EMPTY : MODE_DRAIN;

  always_comb begin
    w_iss_a    = w_cmp[0];
    w_iss_b    = w_cmp[1];
    w_iss_a_v  = 1'b0;
    w_iss_b_v  = 1'b0;
    w_push_ent = w_cmp;
    w_push_cnt = '0;
    w_pop_cnt  = '0;
    if (w_mode == MODE_EMPTY) begin
      w_iss_a_v     = (w_ncmp >= 2'd1);
      w_iss_b_v     = (w_ncmp >= 2'd2);
      w_push_ent[0] = w_cmp[2];
      w_push_cnt    = (w_ncmp == 2'd3) ? 2'd1 : 2'd0;
    end else begin
      w_push_cnt = w_ncmp;
      w_pop_cnt  = (w_fcnt >= (AW+1)'(2)) ? 2'd2 : w_fcnt[1:0];
      w_iss_a    = w_head0;
      w_iss_b    = w_head1;
      w_iss_a_v  = (w_pop_cnt >= 2'd1);
      w_iss_b_v  = (w_pop_cnt == 2'd2);
    end
  end

  assign w_kill_a = w_iss_a_v && w_iss_b_v && (w_iss_a.rd == w_iss_b.rd);

`ifdef WB_MERGE_FWD_EN
  logic [AW-1:0] w_head_ptr;
  wb_ent_t       w_mem [DEPTH];
`endif

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push_cnt (w_push_cnt),
    .i_push_ent (w_push_ent),
    .i_pop_cnt  (w_pop_cnt),
    .o_head0    (w_head0),
    .o_head1    (w_head1),
    .o_cnt      (w_fcnt)
`ifdef WB_MERGE_FWD_EN
    , .o_head_ptr (w_head_ptr)
    , .o_mem      (w_mem)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_a    <= 1'b0;
      rf_waddr_a <= '0;
      rf_wdata_a <= '0;
      rf_we_b    <= 1'b0;
      rf_waddr_b <= '0;
      rf_wdata_b <= '0;
    end else begin
      rf_we_a    <= w_iss_a_v && !w_kill_a;
      rf_waddr_a <= w_iss_a.rd;
      rf_wdata_a <= w_iss_a.data;
      rf_we_b    <= w_iss_b_v;
      rf_waddr_b <= w_iss_b.rd;
      rf_wdata_b <= w_iss_b.data;
    end
  end

  assign fifo_cnt = w_fcnt;
  assign wb_stall = (w_fcnt >= (AW+1)'(DEPTH - 3));

`ifdef WB_MERGE_FWD_EN
  // Walk from head to tail so a later (younger) match overrides an earlier one.
  always_comb begin
    fwd_hit0  = 1'b0;
    fwd_hit1  = 1'b0;
    fwd_data0 = '0;
    fwd_data1 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((AW+1)'(k) < w_fcnt) begin
        if (rs_q0 != '0 && w_mem[w_head_ptr + AW'(k)].rd == rs_q0) begin
          fwd_hit0  = 1'b1;
          fwd_data0 = w_mem[w_head_ptr + AW'(k)].data;
        end
        if (rs_q1 != '0 && w_mem[w_head_ptr + AW'(k)].rd == rs_q1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = w_mem[w_head_ptr + AW'(k)].data;
        end
      end
    end
  end
`else
  logic w_unused_rs;
  assign w_unused_rs = ^{rs_q0, rs_q1};
  assign fwd_hit0  = 1'b0;
  assign fwd_hit1  = 1'b0;
  assign fwd_data0 = '0;
  assign fwd_data1 = '0;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Directed self-checking bench for wb_merge; forwarding expectations follow WB_MERGE_FWD_EN.
module tb_wb_merge;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef WB_MERGE_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, we2;
  logic [4:0]  rd0, rd1, rd2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic        rf_we_a, rf_we_b;
  logic [4:0]  rf_waddr_a, rf_waddr_b;
  logic [31:0] rf_wdata_a, rf_wdata_b;
  logic        wb_stall;
  logic [AW:0] fifo_cnt;
  logic [4:0]  rs_q0, rs_q1;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] rf_model [32];
  logic [31:0] gold     [32];
  logic [AW:0] exp_cnt  [4];

  always #5 clk = ~clk;

  wb_merge #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we0        (we0),
    .rd0        (rd0),
    .wdata0     (wdata0),
    .we1        (we1),
    .rd1        (rd1),
    .wdata1     (wdata1),
    .we2        (we2),
    .rd2        (rd2),
    .wdata2     (wdata2),
    .rf_we_a    (rf_we_a),
    .rf_waddr_a (rf_waddr_a),
    .rf_wdata_a (rf_wdata_a),
    .rf_we_b    (rf_we_b),
    .rf_waddr_b (rf_waddr_b),
    .rf_wdata_b (rf_wdata_b),
    .wb_stall   (wb_stall),
    .fifo_cnt   (fifo_cnt),
    .rs_q0      (rs_q0),
    .rs_q1      (rs_q1),
    .fwd_hit0   (fwd_hit0),
    .fwd_hit1   (fwd_hit1),
    .fwd_data0  (fwd_data0),
    .fwd_data1  (fwd_data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic e2, input logic [4:0] a2, input logic [31:0] d2,
                       input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    we2 = e2; rd2 = a2; wdata2 = d2;
    we0 = e0; rd0 = a0; wdata0 = d0;
    we1 = e1; rd1 = a1; wdata1 = d1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Advance one edge, then record what the register file would have absorbed.
  task automatic tick;
    @(posedge clk);
    #1;
    if (rf_we_a) rf_model[rf_waddr_a] = rf_wdata_a;
    if (rf_we_b) rf_model[rf_waddr_b] = rf_wdata_b;
  endtask

  task automatic drain;
    int unsigned n = 0;
    while (fifo_cnt != '0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(fifo_cnt), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rs_q0 = '0;
    rs_q1 = '0;
    idle();
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    tick();
    tick();
    check("rst_cnt",   32'(fifo_cnt),   32'd0);
    check("rst_we_a",  32'(rf_we_a),    32'd0);
    check("rst_we_b",  32'(rf_we_b),    32'd0);
    check("rst_addr_a", 32'(rf_waddr_a), 32'd0);
    check("rst_data_b", rf_wdata_b,      32'd0);
    check("rst_stall", 32'(wb_stall),   32'd0);
    check("rst_hit0",  32'(fwd_hit0),   32'd0);
    reset = 1'b0;

    // Two writes, empty FIFO: direct issue on both ports
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    tick();
    idle();
    check("dir_we_a",   32'(rf_we_a),    32'd1);
    check("dir_addr_a", 32'(rf_waddr_a), 32'd5);
    check("dir_data_a", rf_wdata_a,      32'h11);
    check("dir_we_b",   32'(rf_we_b),    32'd1);
    check("dir_addr_b", 32'(rf_waddr_b), 32'd6);
    check("dir_data_b", rf_wdata_b,      32'h22);
    check("dir_cnt",    32'(fifo_cnt),   32'd0);

    // Three writes: ch2, ch0 issue, ch1 buffered and issued next cycle
    drive(1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, 1'b1, 5'd9, 32'hCC);
    tick();
    idle();
    check("t3_addr_a", 32'(rf_waddr_a), 32'd7);
    check("t3_data_a", rf_wdata_a,      32'hAA);
    check("t3_addr_b", 32'(rf_waddr_b), 32'd8);
    check("t3_data_b", rf_wdata_b,      32'hBB);
    check("t3_cnt",    32'(fifo_cnt),   32'd1);
    tick();
    check("t3q_we_a",   32'(rf_we_a),    32'd1);
    check("t3q_addr_a", 32'(rf_waddr_a), 32'd9);
    check("t3q_data_a", rf_wdata_a,      32'hCC);
    check("t3q_we_b",   32'(rf_we_b),    32'd0);
    check("t3q_cnt",    32'(fifo_cnt),   32'd0);

    // Same rd on both issued writes: older killed
    drive(1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    check("col_we_a",   32'(rf_we_a),    32'd0);
    check("col_we_b",   32'(rf_we_b),    32'd1);
    check("col_addr_b", 32'(rf_waddr_b), 32'd4);
    check("col_data_b", rf_wdata_b,      32'h2);
    tick();

    // Buffer r8, r3=0x10, r3=0x20 then look up r3
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'h7);
    tick();
    drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd3, 32'h10, 1'b1, 5'd3, 32'h20);
    tick();
    idle();
    check("fwd_cnt", 32'(fifo_cnt), 32'd3);
    rs_q0 = 5'd3;
    rs_q1 = 5'd0;
    #1;
    check("fwd_hit0",  32'(fwd_hit0),  32'(FWD));
    check("fwd_data0", fwd_data0,      FWD ? 32'h20 : 32'h0);
    check("fwd_hit1",  32'(fwd_hit1),  32'd0);
    rs_q1 = 5'd8;
    #1;
    check("fwd_hit1b",  32'(fwd_hit1), 32'(FWD));
    check("fwd_data1b", fwd_data1,     FWD ? 32'h8 : 32'h0);
    rs_q0 = '0;
    rs_q1 = '0;
    drain();

    // Reset with four entries buffered
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 1'b1, 5'd12, 32'h102);
      tick();
    end
    idle();
    check("pre_rst_cnt", 32'(fifo_cnt), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cnt",   32'(fifo_cnt), 32'd0);
    check("mid_rst_we_a",  32'(rf_we_a),  32'd0);
    check("mid_rst_we_b",  32'(rf_we_b),  32'd0);
    check("mid_rst_stall", 32'(wb_stall), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    tick();
    idle();
    check("rd0_we_a", 32'(rf_we_a),  32'd0);
    check("rd0_we_b", 32'(rf_we_b),  32'd0);
    check("rd0_cnt",  32'(fifo_cnt), 32'd0);

    // Backpressure: 4 cycles of three writes, then load-only
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      gold[i]     = '0;
    end
    exp_cnt[0] = 4'd1;
    exp_cnt[1] = 4'd3;
    exp_cnt[2] = 4'd4;
    exp_cnt[3] = 4'd5;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'((3*c)   % 6 + 1), 32'(32'h100 + 3*c),
            1'b1, 5'((3*c+1) % 6 + 1), 32'(32'h100 + 3*c + 1),
            1'b1, 5'((3*c+2) % 6 + 1), 32'(32'h100 + 3*c + 2));
      tick();
      check("bp_cnt",   32'(fifo_cnt), 32'(exp_cnt[c]));
      check("bp_stall", 32'(wb_stall), (exp_cnt[c] >= 4'd5) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 5'(12 % 6 + 1), 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check("bp_ld1_cnt", 32'(fifo_cnt), 32'd4);
    drive(1'b1, 5'(13 % 6 + 1), 32'h10D, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    check("bp_ld2_cnt", 32'(fifo_cnt), 32'd3);
    drain();
    for (int i = 0; i < 14; i++) gold[i % 6 + 1] = 32'(32'h100 + i);
    for (int r = 0; r < 8; r++) check($sformatf("bp_rf_r%0d", r), rf_model[r], gold[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
